// File: rtl/shift_pkg.sv
// Shared encodings for the shift issue pipe: op codes, one-hot shifter selects, default widths.
package shift_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 4;
  localparam int SHAMT_W    = 5;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  localparam logic [2:0] SHF_NONE = 3'b000;
  localparam logic [2:0] SHF_SLL  = 3'b001;
  localparam logic [2:0] SHF_SRL  = 3'b010;
  localparam logic [2:0] SHF_SRA  = 3'b100;

  function automatic logic [2:0] op_to_shf(input logic [1:0] op);
    logic [2:0] f;
    case (op)
      OP_SLL:  f = SHF_SLL;
      OP_SRL:  f = SHF_SRL;
      OP_SRA:  f = SHF_SRA;
      default: f = SHF_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/shift_stage_reg.sv
// Pipeline stage: valid bit plus payload register; clear beats load, load beats drain.
// Payload only changes on load, so it holds while the stage is stalled.
module shift_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic         i_drain,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  output logic [W-1:0] o_dat
);

  logic         r_vld;
  logic [W-1:0] r_dat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else begin
      if (i_clr)        r_vld <= 1'b0;
      else if (i_load)  r_vld <= 1'b1;
      else if (i_drain) r_vld <= 1'b0;
      if (i_load) r_dat <= i_dat;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/shift_issue_pipe.sv
// Two-stage shift pipe: S1 issues to an external combinational shifter, S2 captures its result.
// One op per cycle, 2-cycle latency; S1 stalls only while S2 is full and out_ready is low.
module shift_issue_pipe
  import shift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              flush,
  output logic [DATA_W-1:0] sh_a,
  output logic [DATA_W-1:0] sh_b,
  output logic [2:0]        sh_f,
  input  logic [DATA_W-1:0] sh_c,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_c,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_zero,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  localparam int S1_W = 2 + SHAMT_W + DATA_W + TAG_W;
  localparam int S2_W = 2 + DATA_W + TAG_W;

  logic                w_s1_vld;
  logic                w_s2_vld;
  logic                w_s1_adv;
  logic                w_acc;
  logic                w_in_ill;
  logic [S1_W-1:0]     w_s1_din;
  logic [S1_W-1:0]     w_s1_q;
  logic [1:0]          w_s1_op;
  logic [SHAMT_W-1:0]  w_s1_b;
  logic [DATA_W-1:0]   w_s1_a;
  logic [TAG_W-1:0]    w_s1_tag;
  logic                w_s1_ill;
  logic [DATA_W-1:0]   w_res;
  logic [S2_W-1:0]     w_s2_din;
  logic [S2_W-1:0]     w_s2_q;
  logic                w_unused_b;
  logic [7:0]          r_err_cnt;

  // S1 may refill in the same cycle it hands its op to S2.
  assign w_s1_adv = w_s1_vld && (!w_s2_vld || out_ready);
  assign in_ready = !flush && (!w_s1_vld || w_s1_adv);
  assign w_acc    = in_valid && in_ready;
  assign w_in_ill = (in_op == OP_ILL);

  assign w_s1_din   = {in_op, in_b[SHAMT_W-1:0], in_a, in_tag};
  assign w_unused_b = ^in_b[DATA_W-1:SHAMT_W];

  shift_stage_reg #(.W(S1_W)) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (flush),
    .i_load  (w_acc),
    .i_drain (w_s1_adv),
    .i_dat   (w_s1_din),
    .o_vld   (w_s1_vld),
    .o_dat   (w_s1_q)
  );

  assign {w_s1_op, w_s1_b, w_s1_a, w_s1_tag} = w_s1_q;
  assign w_s1_ill = (w_s1_op == OP_ILL);

  assign sh_a = w_s1_a;
  assign sh_b = {{(DATA_W-SHAMT_W){1'b0}}, w_s1_b};
  assign sh_f = w_s1_vld ? op_to_shf(w_s1_op) : SHF_NONE;

  // Illegal ops never reach the shifter; their result is forced to zero here.
  assign w_res    = w_s1_ill ? '0 : sh_c;
  assign w_s2_din = {w_s1_ill, (w_res == '0), w_res, w_s1_tag};

  shift_stage_reg #(.W(S2_W)) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (flush),
    .i_load  (w_s1_adv && !flush),
    .i_drain (out_ready),
    .i_dat   (w_s2_din),
    .o_vld   (w_s2_vld),
    .o_dat   (w_s2_q)
  );

  assign out_valid = w_s2_vld;
  assign {out_err, out_zero, out_c, out_tag} = w_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'd0;
    end else if (w_acc && w_in_ill && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_shift_issue_pipe.sv
// Randomized + directed bench for shift_issue_pipe with a queue scoreboard and a reference shifter.
module tb_shift_issue_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic        flush;
  logic [31:0] sh_a;
  logic [31:0] sh_b;
  logic [2:0]  sh_f;
  logic [31:0] sh_c;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_c;
  logic [3:0]  out_tag;
  logic        out_zero;
  logic        out_err;
  logic [7:0]  err_cnt;

  always #10 clk = ~clk;

  shift_issue_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .flush     (flush),
    .sh_a      (sh_a),
    .sh_b      (sh_b),
    .sh_f      (sh_f),
    .sh_c      (sh_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_tag   (out_tag),
    .out_zero  (out_zero),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  // External combinational shifter driven by the DUT's issue stage.
  logic signed [31:0] w_sa;
  logic [31:0]        w_sra;
  assign w_sa  = sh_a;
  assign w_sra = w_sa >>> sh_b;
  assign sh_c  = (sh_f == 3'b001) ? (sh_a << sh_b) :
                 (sh_f == 3'b010) ? (sh_a >> sh_b) :
                 (sh_f == 3'b100) ? w_sra : 32'h0;

  typedef struct {
    logic [31:0] c;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_errs = 0;

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int                 n;
    logic signed [31:0] sa;
    n  = int'(b & 32'd31);
    sa = a;
    case (op)
      2'd0:    return a << n;
      2'd1:    return a >> n;
      2'd2:    return sa >>> n;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
    check({pfx, "_out_c"},     64'(out_c),     64'd0);
    check({pfx, "_out_tag"},   64'(out_tag),   64'd0);
    check({pfx, "_out_zero"},  64'(out_zero),  64'd0);
    check({pfx, "_out_err"},   64'(out_err),   64'd0);
    check({pfx, "_err_cnt"},   64'(err_cnt),   64'd0);
    check({pfx, "_sh_f"},      64'(sh_f),      64'd0);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  // Record accepted requests just before the edge that accepts them.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && in_valid && in_ready) begin
      e.c   = ref_shift(in_op, in_a, in_b);
      e.tag = in_tag;
      e.err = (in_op == 2'b11);
      sbq.push_back(e);
      if (in_op == 2'b11 && exp_errs < 255) exp_errs++;
    end
  end

  logic        stalled = 1'b0;
  logic [31:0] h_c;
  logic [3:0]  h_tag;
  logic        h_zero;
  logic        h_err;

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n) check("err_cnt", 64'(err_cnt), 64'(exp_errs));
    #2;
    if (rst_n && stalled && out_valid) begin
      check("hold_c",    64'(out_c),    64'(h_c));
      check("hold_tag",  64'(out_tag),  64'(h_tag));
      check("hold_zero", 64'(out_zero), 64'(h_zero));
      check("hold_err",  64'(out_err),  64'(h_err));
    end
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: tag 0x%0h c 0x%0h with no request outstanding", out_tag, out_c);
      end else begin
        e = sbq.pop_front();
        check("out_c",    64'(out_c),    64'(e.c));
        check("out_tag",  64'(out_tag),  64'(e.tag));
        check("out_zero", 64'(out_zero), 64'(e.c == 32'h0));
        check("out_err",  64'(out_err),  64'(e.err));
      end
    end
    stalled = rst_n && out_valid && !out_ready;
    h_c    = out_c;
    h_tag  = out_tag;
    h_zero = out_zero;
    h_err  = out_err;
    if (flush) sbq.delete();
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    logic acc;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    repeat (2) @(negedge clk);
    #1 check_reset("init");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("in_ready_after_rst", 64'(in_ready), 64'd1);

    // SLL latency
    @(negedge clk);
    drive(1'b1, 2'd0, 32'h1, 32'd4, 4'h5);
    @(negedge clk);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    #1 check("d1_valid_early", 64'(out_valid), 64'd0);
    @(negedge clk);
    #1 check("d1_out_valid", 64'(out_valid), 64'd1);
    check("d1_out_c", 64'(out_c), 64'h10);
    check("d1_out_zero", 64'(out_zero), 64'd0);

    // SRA / SRL with oversize shift amount
    @(negedge clk);
    drive(1'b1, 2'd2, 32'h8000_0000, 32'h3F, 4'h6);
    @(negedge clk);
    drive(1'b1, 2'd1, 32'h8000_0000, 32'h3F, 4'h7);
    #1 check("d2_sh_b", 64'(sh_b), 64'd31);
    check("d2_sh_f_sra", 64'(sh_f), 64'b100);
    check("d2_sh_a", 64'(sh_a), 64'h8000_0000);
    @(negedge clk);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    #1 check("d2_sh_f_srl", 64'(sh_f), 64'b010);
    check("d2_sra_c", 64'(out_c), 64'hFFFF_FFFF);
    @(negedge clk);
    #1 check("d2_srl_c", 64'(out_c), 64'h1);
    check("d2_idle_sh_f", 64'(sh_f), 64'd0);

    // back-to-back with a 3-cycle downstream stall
    @(negedge clk);
    cyc = 0;
    for (int t = 1; t <= 4; t++) begin
      drive(1'b1, 2'd0, 32'(t), 32'(t), 4'(t));
      do begin
        out_ready = (cyc >= 3);
        #2;
        acc = in_ready;
        if (cyc == 2) check("d3_stall_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        cyc++;
      end while (!acc && cyc < 30);
    end
    drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);

    // flush with both stages full and a pending request
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 32'h1, 32'h1, 4'h1);
    @(negedge clk);
    drive(1'b1, 2'd0, 32'h2, 32'h1, 4'h2);
    @(negedge clk);
    drive(1'b1, 2'd3, 32'h3, 32'h0, 4'h3);
    flush = 1'b1;
    #1 check("d5_in_ready_flush", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    out_ready = 1'b1;
    #1 check("d5_out_valid", 64'(out_valid), 64'd0);
    check("d5_sh_f", 64'(sh_f), 64'd0);
    check("d5_err_cnt", 64'(err_cnt), 64'd0);
    repeat (4) @(negedge clk);

    // illegal op and counter saturation
    drive(1'b1, 2'd3, 32'h1234, 32'h0, 4'h9);
    @(negedge clk);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    #1 check("d4_out_valid", 64'(out_valid), 64'd1);
    check("d4_out_c", 64'(out_c), 64'd0);
    check("d4_out_err", 64'(out_err), 64'd1);
    check("d4_out_zero", 64'(out_zero), 64'd1);
    check("d4_err_cnt", 64'(err_cnt), 64'd1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(1'b1, 2'd3, $urandom, $urandom, 4'($urandom_range(0, 15)));
    end
    @(negedge clk);
    drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    #1 check("d4_err_sat", 64'(err_cnt), 64'hFF);

    // random traffic with a mid-stream reset
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 9) < 7,
            ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
            $urandom, $urandom, 4'($urandom_range(0, 15)));
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      if (i == 300) begin
        #5 rst_n = 1'b0;
        sbq.delete();
        exp_errs = 0;
        #1 check_reset("mid");
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
        rst_n = 1'b1;
        #1 check("in_ready_after_mid_rst", 64'(in_ready), 64'd1);
      end
    end
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 32'h0, 4'h0);
    repeat (8) @(negedge clk);
    #4 check("sb_drained", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
